// File: rtl/tracker_pkg.sv
// Shared definitions for the line tracker: direction codes used by the motor
// driver, tracking state encoding, sensor bit positions and small helpers.
package tracker_pkg;

  // Direction codes understood by the motor PWM driver
  localparam logic [1:0] DIR_STOP  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_FWD   = 2'b11;

  // Bit positions inside the {left, mid, right} sensor word
  localparam int SNS_LEFT  = 2;
  localparam int SNS_MID   = 1;
  localparam int SNS_RIGHT = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FWD    = 3'd1,
    ST_TURN_L = 3'd2,
    ST_TURN_R = 3'd3,
    ST_SEARCH = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Running-state decision from the filtered pattern; 101 keeps the current state
  function automatic state_t pattern_state(input logic [2:0] f, input state_t cur);
    logic [2:0] lmr;
    lmr = {f[SNS_LEFT], f[SNS_MID], f[SNS_RIGHT]};
    case (lmr)
      3'b010, 3'b111: pattern_state = ST_FWD;
      3'b100, 3'b110: pattern_state = ST_TURN_L;
      3'b001, 3'b011: pattern_state = ST_TURN_R;
      3'b000:         pattern_state = ST_SEARCH;
      default:        pattern_state = cur;
    endcase
  endfunction

  // Direction code for a state; SEARCH steers toward the last turn taken
  function automatic logic [1:0] dir_of(input state_t st, input logic [1:0] last_turn);
    case (st)
      ST_FWD:    dir_of = DIR_FWD;
      ST_TURN_L: dir_of = DIR_LEFT;
      ST_TURN_R: dir_of = DIR_RIGHT;
      ST_SEARCH: dir_of = last_turn;
      default:   dir_of = DIR_STOP;
    endcase
  endfunction

  // One slew step toward tgt; 11-bit arithmetic so nothing wraps or overshoots
  function automatic logic [9:0] ramp_toward(input logic [9:0] cur, input logic [9:0] tgt,
                                             input logic [9:0] step);
    logic [10:0] up;
    logic [10:0] dn_lim;
    up     = {1'b0, cur} + {1'b0, step};
    dn_lim = {1'b0, tgt} + {1'b0, step};
    if (cur < tgt) begin
      ramp_toward = (up > {1'b0, tgt}) ? tgt : up[9:0];
    end else if (cur > tgt) begin
      ramp_toward = ({1'b0, cur} > dn_lim) ? (cur - step) : tgt;
    end else begin
      ramp_toward = cur;
    end
  endfunction

endpackage

// File: rtl/line_filter.sv
// Sensor conditioning: 2-flop synchroniser followed by a tick-sampled
// stability filter. A pattern is accepted only after FILT_LEN equal samples.
module line_filter
  import tracker_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic [2:0] i_sensor,
  output logic [2:0] o_filt
);

  localparam logic [3:0] ACCEPT_CNT = 4'(FILT_LEN - 1);

  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] r_prev;
  logic [2:0] r_filt;
  logic [3:0] r_stable;
  logic [3:0] w_stable_nxt;

  // Stability count after this tick's sample: saturating run length, cleared on change
  always_comb begin
    w_stable_nxt = 4'd0;
    if (r_sync2 == r_prev) begin
      w_stable_nxt = (r_stable == 4'hF) ? r_stable : (r_stable + 4'd1);
    end else begin
      w_stable_nxt = 4'd0;
    end
  end

  // Synchroniser plus tick-sampled filter registers; filt only moves on ticks
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1  <= 3'b000;
      r_sync2  <= 3'b000;
      r_prev   <= 3'b000;
      r_stable <= 4'd0;
      r_filt   <= 3'b000;
    end else begin
      r_sync1 <= i_sensor;
      r_sync2 <= r_sync1;
      if (i_tick) begin
        r_prev   <= r_sync2;
        r_stable <= w_stable_nxt;
        if (w_stable_nxt >= ACCEPT_CNT) begin
          r_filt <= r_sync2;
        end
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/line_tracker_ctrl.sv
// Line-tracking drive decision: filters the IR sensors, runs the tracking FSM
// and produces the registered direction code and speed word for the motor driver.
// Build option: define SPEED_RAMP_EN for slew-limited speed changes on the
// control tick; without it speed loads the state's target one cycle after the
// state changes.
module line_tracker_ctrl
  import tracker_pkg::*;
#(
  parameter int         TICK_DIV   = 100_000,
  parameter int         FILT_LEN   = 4,
  parameter logic [9:0] SPD_MAX    = 10'd700,
  parameter logic [9:0] SPD_TURN   = 10'd550,
  parameter logic [9:0] RAMP_STEP  = 10'd10,
  parameter int         LOST_TICKS = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] sensor,
  output logic [1:0] dir,
  output logic [9:0] speed,
  output logic       lost
);

  localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LCW = $clog2(LOST_TICKS + 1);

  logic [TCW-1:0] r_tick_cnt;
  logic           w_tick;
  logic [2:0]     w_filt;

  state_t         r_state;
  state_t         w_next;
  logic [1:0]     r_last_turn;
  logic [1:0]     w_turn_nxt;
  logic [LCW-1:0] r_lost_cnt;
  logic [1:0]     r_dir;
  logic [9:0]     r_speed;
  logic           r_lost;
  logic [9:0]     w_target;
  logic [9:0]     w_speed_nxt;

  assign w_tick = (r_tick_cnt == TCW'(TICK_DIV - 1));

  // Free-running control tick divider
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TCW'(1);
    end
  end

  line_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .i_tick   (w_tick),
    .i_sensor (sensor),
    .o_filt   (w_filt)
  );

  // Next tracking state; en low overrides everything, HALT waits for en low
  always_comb begin
    w_next = r_state;
    if (!en) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_next = ST_FWD;
        ST_FWD,
        ST_TURN_L,
        ST_TURN_R: w_next = pattern_state(w_filt, r_state);
        ST_SEARCH: begin
          if ((r_lost_cnt == LCW'(LOST_TICKS)) && (w_filt == 3'b000)) begin
            w_next = ST_HALT;
          end else begin
            w_next = pattern_state(w_filt, r_state);
          end
        end
        ST_HALT:   w_next = ST_HALT;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  // Remember which way we last turned so SEARCH sweeps that way
  always_comb begin
    w_turn_nxt = r_last_turn;
    if (w_next == ST_TURN_L) begin
      w_turn_nxt = DIR_LEFT;
    end else if (w_next == ST_TURN_R) begin
      w_turn_nxt = DIR_RIGHT;
    end else begin
      w_turn_nxt = r_last_turn;
    end
  end

  // Speed target for the state currently being driven
  always_comb begin
    case (r_state)
      ST_FWD:    w_target = SPD_MAX;
      ST_TURN_L,
      ST_TURN_R,
      ST_SEARCH: w_target = SPD_TURN;
      default:   w_target = 10'd0;
    endcase
  end

  // Next speed: hard stop on entering IDLE/HALT, otherwise follow the target
  always_comb begin
    w_speed_nxt = r_speed;
    if ((w_next == ST_IDLE) || (w_next == ST_HALT)) begin
      w_speed_nxt = 10'd0;
`ifdef SPEED_RAMP_EN
    end else if (w_tick) begin
      w_speed_nxt = ramp_toward(r_speed, w_target, RAMP_STEP);
    end else begin
      w_speed_nxt = r_speed;
    end
`else
    end else begin
      w_speed_nxt = w_target;
    end
`endif
  end

  // Tracking FSM with registered outputs and the SEARCH timeout counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_last_turn <= DIR_LEFT;
      r_lost_cnt  <= '0;
      r_dir       <= DIR_STOP;
      r_speed     <= 10'd0;
      r_lost      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_last_turn <= w_turn_nxt;
      r_dir       <= dir_of(w_next, w_turn_nxt);
      r_lost      <= (w_next == ST_HALT);
      r_speed     <= w_speed_nxt;
      if ((r_state == ST_SEARCH) && (w_next == ST_SEARCH)) begin
        if (w_tick && (r_lost_cnt != LCW'(LOST_TICKS))) begin
          r_lost_cnt <= r_lost_cnt + LCW'(1);
        end
      end else begin
        r_lost_cnt <= '0;
      end
    end
  end

  assign dir   = r_dir;
  assign speed = r_speed;
  assign lost  = r_lost;

endmodule
